// File: rtl/draw_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// draw_cmd_arbiter
//
// Merges draw commands from two requesters (0 = game core, 1 = overlay/menu)
// into a single draw-engine command stream. Each requester has its own FIFO
// because the requesters cannot be stalled. The arbiter serves whole
// commands: a two-word command (opcode 4'h9 or 4'ha in the top nibble) keeps
// ownership until its second word has gone out, even if that word arrives
// late. Ties between requesters are broken round-robin at command boundaries.
//
// Ports
//   clk        : clock
//   rst        : synchronous reset, active high
//   req0_cmd   : requester 0 command word
//   req0_vld   : requester 0 strobe (no backpressure)
//   req1_cmd   : requester 1 command word
//   req1_vld   : requester 1 strobe (no backpressure)
//   cmd        : command word to the draw engine
//   cmd_vld    : cmd is valid
//   cmd_rdy    : draw engine accepts (transfer when cmd_vld & cmd_rdy)
//   grant      : one-hot current owner, 2'b00 when idle
//   ovf0/ovf1  : sticky overflow flags, cleared only by rst
//
// FSM states
//   state | meaning
//   IDLE  | no owner; waits for any non-empty FIFO, pops the winner's head
//   SEND1 | first (or only) word presented on cmd
//   WAIT2 | two-word command, second word not yet in owner's FIFO; grant held
//   SEND2 | second word presented on cmd
// ---------------------------------------------------------------------------
module draw_cmd_arbiter #(
    parameter int CMD_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CMD_WIDTH-1:0] req0_cmd,
    input  logic                 req0_vld,
    input  logic [CMD_WIDTH-1:0] req1_cmd,
    input  logic                 req1_vld,
    output logic [CMD_WIDTH-1:0] cmd,
    output logic                 cmd_vld,
    input  logic                 cmd_rdy,
    output logic [1:0]           grant,
    output logic                 ovf0,
    output logic                 ovf1
);

    localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND1 = 2'd1,
        WAIT2 = 2'd2,
        SEND2 = 2'd3
    } state_t;

    function automatic logic is_two_word(input logic [3:0] opc);
        return (opc == 4'h9) || (opc == 4'ha);
    endfunction

    // ------------------------------------------------------------------
    // Per-requester FIFO storage, index 0 = requester 0, 1 = requester 1
    // ------------------------------------------------------------------
    logic [CMD_WIDTH-1:0] mem     [2][FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wptr    [2];
    logic [FIFO_AW-1:0]   rptr    [2];
    logic [FIFO_AW:0]     count   [2];
    logic [CMD_WIDTH-1:0] data_in [2];
    logic [CMD_WIDTH-1:0] head    [2];
    logic [1:0]           vld_in;
    logic [1:0]           full;
    logic [1:0]           nonempty;
    logic [1:0]           push;
    logic [1:0]           pop;
    logic [1:0]           ovf_q;

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    state_t               state;
    logic                 owner;
    logic                 last_owner;
    logic                 cmd_two;
    logic                 winner;
    logic [CMD_WIDTH-1:0] win_head;
    logic                 win_two;

    always_comb begin
        vld_in     = {req1_vld, req0_vld};
        data_in[0] = req0_cmd;
        data_in[1] = req1_cmd;
        for (int r = 0; r < 2; r++) begin
            full[r]     = (count[r] == DEPTH_CNT);
            nonempty[r] = (count[r] != '0);
            // Fullness is judged on the pre-edge count, so a pop in the same
            // cycle never makes room for a push that arrived while full.
            push[r]     = vld_in[r] & ~full[r];
            head[r]     = mem[r][rptr[r]];
        end
    end

    // Round-robin: with both pending the requester that did not own the
    // last command wins; otherwise whichever FIFO has data.
    always_comb begin
        if (nonempty == 2'b11) begin
            winner = ~last_owner;
        end else begin
            winner = ~nonempty[0];
        end
        win_head = head[winner];
        win_two  = is_two_word(win_head[CMD_WIDTH-1 -: 4]);
    end

    // Pops mirror the FSM transitions below; cmd_vld is always 1 in SEND1,
    // so cmd_rdy alone marks the handshake there.
    always_comb begin
        pop = '0;
        case (state)
            IDLE: begin
                if (|nonempty) begin
                    pop[winner] = 1'b1;
                end
            end
            SEND1: begin
                if (cmd_rdy && cmd_two && nonempty[owner]) begin
                    pop[owner] = 1'b1;
                end
            end
            WAIT2: begin
                if (nonempty[owner]) begin
                    pop[owner] = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                mem[r][wptr[r]] <= data_in[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                wptr[r]  <= '0;
                rptr[r]  <= '0;
                count[r] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r]) begin
                    wptr[r] <= wptr[r] + PTR_ONE;
                end
                if (pop[r]) begin
                    rptr[r] <= rptr[r] + PTR_ONE;
                end
                case ({push[r], pop[r]})
                    2'b10:   count[r] <= count[r] + CNT_ONE;
                    2'b01:   count[r] <= count[r] - CNT_ONE;
                    default: count[r] <= count[r];
                endcase
                ovf_q[r] <= ovf_q[r] | (vld_in[r] & full[r]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= '0;
            cmd_vld    <= 1'b0;
            grant      <= 2'b00;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cmd_two    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|nonempty) begin
                        cmd        <= win_head;
                        cmd_vld    <= 1'b1;
                        grant      <= winner ? 2'b10 : 2'b01;
                        owner      <= winner;
                        last_owner <= winner;
                        cmd_two    <= win_two;
                        state      <= SEND1;
                    end
                end
                SEND1: begin
                    if (cmd_rdy) begin
                        if (!cmd_two) begin
                            cmd_vld <= 1'b0;
                            grant   <= 2'b00;
                            state   <= IDLE;
                        end else if (nonempty[owner]) begin
                            cmd   <= head[owner];
                            state <= SEND2;
                        end else begin
                            // Second word not here yet: drop valid, keep grant.
                            cmd_vld <= 1'b0;
                            state   <= WAIT2;
                        end
                    end
                end
                WAIT2: begin
                    if (nonempty[owner]) begin
                        cmd     <= head[owner];
                        cmd_vld <= 1'b1;
                        state   <= SEND2;
                    end
                end
                SEND2: begin
                    if (cmd_rdy) begin
                        cmd_vld <= 1'b0;
                        grant   <= 2'b00;
                        state   <= IDLE;
                    end
                end
                default: begin
                    cmd_vld <= 1'b0;
                    grant   <= 2'b00;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ovf0 = ovf_q[0];
    assign ovf1 = ovf_q[1];

endmodule
